// File: rtl/instruction_encoder_pkg.sv
// Shared constants for the MIPS instruction encoder.
// Holds the one-hot request bit positions, opcode and funct values, field offsets,
// default parameters, and the buffered entry layout.
package instruction_encoder_pkg;

  // Default build parameters
  localparam int          DEFAULT_FIFO_DEPTH = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDR  = 32'h0040_0000;

  // One-hot request bit positions
  localparam logic [4:0] BIT_ADD      = 5'd0;
  localparam logic [4:0] BIT_ADDU     = 5'd1;
  localparam logic [4:0] BIT_SUB      = 5'd2;
  localparam logic [4:0] BIT_SUBU     = 5'd3;
  localparam logic [4:0] BIT_AND      = 5'd4;
  localparam logic [4:0] BIT_OR       = 5'd5;
  localparam logic [4:0] BIT_XOR      = 5'd6;
  localparam logic [4:0] BIT_NOR      = 5'd7;
  localparam logic [4:0] BIT_SLT      = 5'd8;
  localparam logic [4:0] BIT_SLTU     = 5'd9;
  localparam logic [4:0] BIT_SLL      = 5'd10;
  localparam logic [4:0] BIT_SRL      = 5'd11;
  localparam logic [4:0] BIT_SRA      = 5'd12;
  localparam logic [4:0] BIT_SLLV     = 5'd13;
  localparam logic [4:0] BIT_SRLV     = 5'd14;
  localparam logic [4:0] BIT_SRAV     = 5'd15;
  localparam logic [4:0] BIT_JR       = 5'd16;
  localparam logic [4:0] BIT_ADDI     = 5'd17;
  localparam logic [4:0] BIT_ADDIU    = 5'd18;
  localparam logic [4:0] BIT_ANDI     = 5'd19;
  localparam logic [4:0] BIT_ORI      = 5'd20;
  localparam logic [4:0] BIT_XORI     = 5'd21;
  localparam logic [4:0] BIT_LUI      = 5'd22;
  localparam logic [4:0] BIT_LW       = 5'd23;
  localparam logic [4:0] BIT_SW       = 5'd24;
  localparam logic [4:0] BIT_BEQ      = 5'd25;
  localparam logic [4:0] BIT_BNE      = 5'd26;
  localparam logic [4:0] BIT_SLTI     = 5'd27;
  localparam logic [4:0] BIT_SLTIU    = 5'd28;
  localparam logic [4:0] BIT_J        = 5'd29;
  localparam logic [4:0] BIT_JAL      = 5'd30;
  localparam logic [4:0] BIT_RESERVED = 5'd31;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Field LSB positions within the 32-bit word
  localparam int OP_LSB     = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_LSB = 0;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } instr_fmt_e;

  // One buffered output word together with its address
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } fifo_entry_t;

  // A request is legal only when exactly one bit is set and that bit is not the reserved top bit
  function automatic logic code_is_legal(input logic [31:0] code);
    return (code != 32'd0) && ((code & (code - 32'd1)) == 32'd0) && !code[BIT_RESERVED];
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO for encoded words; a simultaneous push and pop is accepted even when full.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW:0]      count_q, count_d;
  logic             full;
  logic             doPush;
  logic             doPop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full || doPop);
  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap naturally
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
    case ({doPush, doPop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/instruction_encoder.sv
// MIPS instruction encoder: registers a one-hot request in stage 1, encodes it there,
// tags it with a running address and buffers it for a valid/ready consumer.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int          FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_code,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [15:0] count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Stage-1 request registers
  logic        s1Valid_q,  s1Valid_d;
  logic [31:0] s1Code_q,   s1Code_d;
  logic [4:0]  s1Rs_q,     s1Rs_d;
  logic [4:0]  s1Rt_q,     s1Rt_d;
  logic [4:0]  s1Rd_q,     s1Rd_d;
  logic [4:0]  s1Shamt_q,  s1Shamt_d;
  logic [15:0] s1Imm_q,    s1Imm_d;
  logic [25:0] s1Target_q, s1Target_d;

  // Address counter, sticky error and emitted-word counter
  logic [31:0] addr_q,  addr_d;
  logic        err_q,   err_d;
  logic [15:0] count_q, count_d;

  // Decode results
  instr_fmt_e  fmt;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zeroRs;
  logic        keepShamt;
  logic        zeroRtRdShamt;
  logic [4:0]  rsField;
  logic [4:0]  rtField;
  logic [4:0]  rdField;
  logic [4:0]  shamtField;
  logic [31:0] encoded;

  logic        accept;
  logic        s1Legal;
  logic        s1Push;
  logic        s1Drop;
  logic        outFire;
  logic [CW-1:0] fifoCount;
  logic [CW-1:0] occupancy;
  logic        fifoEmpty;
  fifo_entry_t pushEntry;
  fifo_entry_t headEntry;

  // Readiness comes from registered occupancy only, and is forced low while reset is held
  assign occupancy = fifoCount + CW'(s1Valid_q);
  assign in_ready  = !rst && (occupancy < CW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;

  assign s1Legal = code_is_legal(s1Code_q);
  assign s1Push  = s1Valid_q && s1Legal;
  assign s1Drop  = s1Valid_q && !s1Legal;

  assign out_valid = !fifoEmpty;
  assign outFire   = out_valid && out_ready;
  assign out_instr = fifoEmpty ? 32'd0 : headEntry.instr;
  assign out_addr  = fifoEmpty ? BASE_ADDR : headEntry.addr;
  assign err       = err_q;
  assign count     = count_q;

  // Map the one-hot select to format, opcode, funct and field-forcing flags
  always_comb begin
    fmt           = FMT_R;
    opcode        = OP_SPECIAL;
    funct         = FN_SLL;
    zeroRs        = 1'b0;
    keepShamt     = 1'b0;
    zeroRtRdShamt = 1'b0;
    case (1'b1)
      s1Code_q[BIT_ADD]:   funct = FN_ADD;
      s1Code_q[BIT_ADDU]:  funct = FN_ADDU;
      s1Code_q[BIT_SUB]:   funct = FN_SUB;
      s1Code_q[BIT_SUBU]:  funct = FN_SUBU;
      s1Code_q[BIT_AND]:   funct = FN_AND;
      s1Code_q[BIT_OR]:    funct = FN_OR;
      s1Code_q[BIT_XOR]:   funct = FN_XOR;
      s1Code_q[BIT_NOR]:   funct = FN_NOR;
      s1Code_q[BIT_SLT]:   funct = FN_SLT;
      s1Code_q[BIT_SLTU]:  funct = FN_SLTU;
      s1Code_q[BIT_SLL]:   begin funct = FN_SLL; zeroRs = 1'b1; keepShamt = 1'b1; end
      s1Code_q[BIT_SRL]:   begin funct = FN_SRL; zeroRs = 1'b1; keepShamt = 1'b1; end
      s1Code_q[BIT_SRA]:   begin funct = FN_SRA; zeroRs = 1'b1; keepShamt = 1'b1; end
      s1Code_q[BIT_SLLV]:  funct = FN_SLLV;
      s1Code_q[BIT_SRLV]:  funct = FN_SRLV;
      s1Code_q[BIT_SRAV]:  funct = FN_SRAV;
      s1Code_q[BIT_JR]:    begin funct = FN_JR; zeroRtRdShamt = 1'b1; end
      s1Code_q[BIT_ADDI]:  begin fmt = FMT_I; opcode = OP_ADDI;  end
      s1Code_q[BIT_ADDIU]: begin fmt = FMT_I; opcode = OP_ADDIU; end
      s1Code_q[BIT_ANDI]:  begin fmt = FMT_I; opcode = OP_ANDI;  end
      s1Code_q[BIT_ORI]:   begin fmt = FMT_I; opcode = OP_ORI;   end
      s1Code_q[BIT_XORI]:  begin fmt = FMT_I; opcode = OP_XORI;  end
      s1Code_q[BIT_LUI]:   begin fmt = FMT_I; opcode = OP_LUI; zeroRs = 1'b1; end
      s1Code_q[BIT_LW]:    begin fmt = FMT_I; opcode = OP_LW;    end
      s1Code_q[BIT_SW]:    begin fmt = FMT_I; opcode = OP_SW;    end
      s1Code_q[BIT_BEQ]:   begin fmt = FMT_I; opcode = OP_BEQ;   end
      s1Code_q[BIT_BNE]:   begin fmt = FMT_I; opcode = OP_BNE;   end
      s1Code_q[BIT_SLTI]:  begin fmt = FMT_I; opcode = OP_SLTI;  end
      s1Code_q[BIT_SLTIU]: begin fmt = FMT_I; opcode = OP_SLTIU; end
      s1Code_q[BIT_J]:     begin fmt = FMT_J; opcode = OP_J;     end
      s1Code_q[BIT_JAL]:   begin fmt = FMT_J; opcode = OP_JAL;   end
      default:             fmt = FMT_R;
    endcase
  end

  // Apply field forcing and assemble the final word for the decoded format
  always_comb begin
    rsField    = zeroRs ? 5'd0 : s1Rs_q;
    rtField    = zeroRtRdShamt ? 5'd0 : s1Rt_q;
    rdField    = zeroRtRdShamt ? 5'd0 : s1Rd_q;
    shamtField = (keepShamt && !zeroRtRdShamt) ? s1Shamt_q : 5'd0;
    encoded    = 32'd0;
    case (fmt)
      FMT_R: encoded = (32'(opcode)     << OP_LSB)
                     | (32'(rsField)    << RS_LSB)
                     | (32'(rtField)    << RT_LSB)
                     | (32'(rdField)    << RD_LSB)
                     | (32'(shamtField) << SHAMT_LSB)
                     | 32'(funct);
      FMT_I: encoded = (32'(opcode)  << OP_LSB)
                     | (32'(rsField) << RS_LSB)
                     | (32'(rtField) << RT_LSB)
                     | (32'(s1Imm_q) << IMM_LSB);
      FMT_J: encoded = (32'(opcode)     << OP_LSB)
                     | (32'(s1Target_q) << TARGET_LSB);
      default: encoded = 32'd0;
    endcase
  end

  assign pushEntry.instr = encoded;
  assign pushEntry.addr  = addr_q;

  // Next-state for stage 1, address counter, sticky error and emitted count
  always_comb begin
    s1Valid_d  = accept;
    s1Code_d   = s1Code_q;
    s1Rs_d     = s1Rs_q;
    s1Rt_d     = s1Rt_q;
    s1Rd_d     = s1Rd_q;
    s1Shamt_d  = s1Shamt_q;
    s1Imm_d    = s1Imm_q;
    s1Target_d = s1Target_q;
    if (accept) begin
      s1Code_d   = in_code;
      s1Rs_d     = in_rs;
      s1Rt_d     = in_rt;
      s1Rd_d     = in_rd;
      s1Shamt_d  = in_shamt;
      s1Imm_d    = in_imm;
      s1Target_d = in_target;
    end
    addr_d  = s1Push ? (addr_q + 32'd4) : addr_q;
    err_d   = err_q | s1Drop;
    count_d = outFire ? (count_q + 16'd1) : count_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Code_q   <= 32'd0;
      s1Rs_q     <= 5'd0;
      s1Rt_q     <= 5'd0;
      s1Rd_q     <= 5'd0;
      s1Shamt_q  <= 5'd0;
      s1Imm_q    <= 16'd0;
      s1Target_q <= 26'd0;
      addr_q     <= BASE_ADDR;
      err_q      <= 1'b0;
      count_q    <= 16'd0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Code_q   <= s1Code_d;
      s1Rs_q     <= s1Rs_d;
      s1Rt_q     <= s1Rt_d;
      s1Rd_q     <= s1Rd_d;
      s1Shamt_q  <= s1Shamt_d;
      s1Imm_q    <= s1Imm_d;
      s1Target_q <= s1Target_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      count_q    <= count_d;
    end
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (s1Push),
    .wdata_i (pushEntry),
    .pop_i   (outFire),
    .rdata_o (headEntry),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: stimulus pushes expected words, a monitor pops and compares.
module tb_instruction_encoder;

  localparam logic [31:0] BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_code;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;
  logic [15:0] count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
  } exp_t;

  exp_t        expQ[$];
  int          vecCount = 0;
  int          missCount = 0;
  int          legalIssued = 0;
  int          stallCycles = 0;
  logic [31:0] nextAddr = BASE;

  instruction_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Present one request (called at posedge+1) and hold it until accepted; leaves in_valid high
  task automatic applyStimulus(input logic [31:0] code, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [4:0] shamt, input logic [15:0] imm,
                               input logic [25:0] target, input logic isLegal, input logic [31:0] expInstr);
    int waited;
    logic taken;
    in_valid  = 1'b1;
    in_code   = code;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = shamt;
    in_imm    = imm;
    in_target = target;
    waited = 0;
    taken  = 1'b0;
    while (!taken && waited < 50) begin
      @(negedge clk);
      if (in_ready === 1'b1) taken = 1'b1;
      else waited++;
    end
    if (!taken) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL acceptTimeout: got in_ready=%b, expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      stallCycles += waited;
      if (isLegal) begin
        expQ.push_back('{expInstr, nextAddr});
        nextAddr += 32'd4;
        legalIssued++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    in_code   = 32'd0;
    in_rs     = 5'd0;
    in_rt     = 5'd0;
    in_rd     = 5'd0;
    in_shamt  = 5'd0;
    in_imm    = 16'd0;
    in_target = 26'd0;
  endtask

  // Wait (bounded) until every expected word has been seen and the output is idle
  task automatic waitDrain();
    int n;
    n = 0;
    while (n < 100 && (expQ.size() != 0 || out_valid === 1'b1)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      vecCount++;
      missCount++;
      $display("[TB] FAIL drainTimeout: got %0d words pending, expected 0", expQ.size());
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each word handed to the consumer against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL unexpectedWord: got instr %h addr %h, expected no word", out_instr, out_addr);
        end else begin
          e = expQ.pop_front();
          checkOutput("outInstr", out_instr, e.instr);
          checkOutput("outAddr", out_addr, e.addr);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int stallBefore;
    rst = 1'b1;
    out_ready = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("resetInReady", 32'(in_ready), 32'd0);
    checkOutput("resetOutValid", 32'(out_valid), 32'd0);
    checkOutput("resetOutInstr", out_instr, 32'd0);
    checkOutput("resetOutAddr", out_addr, BASE);
    checkOutput("resetErr", 32'(err), 32'd0);
    checkOutput("resetCount", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("readyAfterReset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Latency: add with the consumer stalled, valid must appear two cycles after accept
    applyStimulus(32'h1 << 0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
    idle();
    @(negedge clk);
    checkOutput("latencyN1Valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("latencyN2Valid", 32'(out_valid), 32'd1);
    checkOutput("latencyN2Instr", out_instr, 32'h0022_1820);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Back-to-back mix of formats and forced fields with the consumer always ready
    stallBefore = stallCycles;
    applyStimulus(32'h1 << 10, 5'd7,  5'd1,  5'd2, 5'd4,  16'h0,    26'h0,       1'b1, 32'h0001_1100);
    applyStimulus(32'h1 << 22, 5'd5,  5'd1,  5'd0, 5'd0,  16'h1234, 26'h0,       1'b1, 32'h3C01_1234);
    applyStimulus(32'h1 << 29, 5'd0,  5'd0,  5'd0, 5'd0,  16'h0,    26'h0100000, 1'b1, 32'h0810_0000);
    applyStimulus(32'h1 << 16, 5'd31, 5'd2,  5'd3, 5'd4,  16'h0,    26'h0,       1'b1, 32'h03E0_0008);
    applyStimulus(32'h1 << 24, 5'd29, 5'd8,  5'd0, 5'd0,  16'hFFFC, 26'h0,       1'b1, 32'hAFA8_FFFC);
    applyStimulus(32'h1 << 25, 5'd1,  5'd2,  5'd0, 5'd0,  16'h0003, 26'h0,       1'b1, 32'h1022_0003);
    applyStimulus(32'h1 << 30, 5'd0,  5'd0,  5'd0, 5'd0,  16'h0,    26'h3FFFFFF, 1'b1, 32'h0FFF_FFFF);
    applyStimulus(32'h1 << 15, 5'd4,  5'd5,  5'd6, 5'd7,  16'h0,    26'h0,       1'b1, 32'h0085_3007);
    applyStimulus(32'h1 << 12, 5'd9,  5'd3,  5'd4, 5'd31, 16'h0,    26'h0,       1'b1, 32'h0003_27C3);
    applyStimulus(32'h1 << 7,  5'd1,  5'd2,  5'd3, 5'd5,  16'h0,    26'h0,       1'b1, 32'h0022_1827);
    idle();
    checkOutput("throughputStalls", 32'(stallCycles - stallBefore), 32'd0);
    waitDrain();
    checkOutput("countAfterBurst", 32'(count), 32'(legalIssued));

    // Illegal codes are dropped, set the sticky flag and consume no address
    checkOutput("errBeforeIllegal", 32'(err), 32'd0);
    applyStimulus(32'h0000_0003, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
    applyStimulus(32'h0000_0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
    applyStimulus(32'h8000_0000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
    applyStimulus(32'h1 << 0,    5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 32'h0022_1820);
    idle();
    waitDrain();
    checkOutput("errAfterIllegal", 32'(err), 32'd1);
    checkOutput("countAfterIllegal", 32'(count), 32'(legalIssued));

    // Backpressure: four fill the buffer, the fifth is held off, head stays stable
    out_ready = 1'b0;
    applyStimulus(32'h1 << 20, 5'd2,  5'd3,  5'd0, 5'd0, 16'h00FF, 26'h0, 1'b1, 32'h3443_00FF);
    applyStimulus(32'h1 << 19, 5'd1,  5'd1,  5'd0, 5'd0, 16'hF0F0, 26'h0, 1'b1, 32'h3021_F0F0);
    applyStimulus(32'h1 << 18, 5'd29, 5'd29, 5'd0, 5'd0, 16'hFFF8, 26'h0, 1'b1, 32'h27BD_FFF8);
    applyStimulus(32'h1 << 21, 5'd4,  5'd5,  5'd0, 5'd0, 16'h1234, 26'h0, 1'b1, 32'h3885_1234);
    in_code = 32'h1 << 8;
    in_rs = 5'd1;
    in_rt = 5'd2;
    in_rd = 5'd3;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checkOutput("inReadyFull", 32'(in_ready), 32'd0);
      checkOutput("holdHeadInstr", out_instr, 32'h3443_00FF);
      checkOutput("holdHeadAddr", out_addr, expQ[0].addr);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(32'h1 << 8,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0,    26'h0, 1'b1, 32'h0022_182A);
    applyStimulus(32'h1 << 23, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 32'h8FBF_0010);
    idle();
    waitDrain();
    checkOutput("countAfterBackpressure", 32'(count), 32'(legalIssued));

    // Reset with words buffered discards them and restarts addressing at the base
    out_ready = 1'b0;
    applyStimulus(32'h1 << 3,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0, 1'b1, 32'h0022_1823);
    applyStimulus(32'h1 << 28, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0007, 26'h0, 1'b1, 32'h2C22_0007);
    applyStimulus(32'h1 << 6,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0,    26'h0, 1'b1, 32'h0022_1826);
    idle();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    expQ.delete();
    nextAddr = BASE;
    legalIssued = 0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("midResetOutValid", 32'(out_valid), 32'd0);
    checkOutput("midResetCount", 32'(count), 32'd0);
    checkOutput("midResetErr", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("postResetNoWord", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    applyStimulus(32'h1 << 17, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h2001_0005);
    idle();
    waitDrain();
    checkOutput("countAfterReset", 32'(count), 32'(legalIssued));
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: output buffer entries, a power of two of at least 2.
REQ-002 Parameter BASE_ADDR, default 32'h0040_0000: address of the first emitted instruction.
REQ-003 clk  in  1  single clock for the block; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  request present.
REQ-006 in_ready  out  1  block can accept a request this cycle.
REQ-007 in_code  in  32  one-hot instruction select, bit assignment per REQ-014.
REQ-008 in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
REQ-009 in_imm  in  16  immediate; in_target  in  26  jump target.
REQ-010 out_valid  out  1  encoded word available.
REQ-011 out_ready  in  1  consumer takes the word.
REQ-012 out_instr  out  32  encoded MIPS word; out_addr  out  32  address the word belongs at.
REQ-013 err  out  1  sticky illegal-code flag; count  out  16  number of words emitted.

Function
REQ-014 Bit-to-op map (funct for bits 0-16, where op=0; opcode otherwise):
- 0 add 20h, 1 addu 21h, 2 sub 22h, 3 subu 23h, 4 and 24h, 5 or 25h, 6 xor 26h, 7 nor 27h
- 8 slt 2Ah, 9 sltu 2Bh, 10 sll 00h, 11 srl 02h, 12 sra 03h, 13 sllv 04h, 14 srlv 06h, 15 srav 07h, 16 jr 08h
- 17 addi 08h, 18 addiu 09h, 19 andi 0Ch, 20 ori 0Dh, 21 xori 0Eh, 22 lui 0Fh, 23 lw 23h, 24 sw 2Bh
- 25 beq 04h, 26 bne 05h, 27 slti 0Ah, 28 sltiu 0Bh
- 29 j 02h, 30 jal 03h
REQ-015 R-format = {op, rs, rt, rd, shamt, funct}; shamt forced 0 except bits 10-12; rs forced 0 for bits 10-12; rt, rd and shamt forced 0 for bit 16.
REQ-016 I-format = {op, rs, rt, imm}; rs forced 0 for bit 22 (lui).
REQ-017 J-format = {op, target}.
REQ-018 Illegal code: zero bits set, more than one bit set, or bit 31 set.
- Request is accepted and then dropped.
- err is set.
- No word, address or count is consumed.
REQ-019 Accept occurs when in_valid && in_ready; fields are registered in stage 1 (encode), then pushed into the FIFO the next cycle.
REQ-020 Latency: a request accepted in cycle N with the FIFO empty shows out_valid in cycle N+2.
REQ-021 in_ready = (fifo_count + s1_valid) < FIFO_DEPTH, computed from registers only.
- Throughput is 1 request per cycle when out_ready is held high.
REQ-022 out_valid = FIFO not empty; out_instr/out_addr show the head entry and hold stable while out_valid && !out_ready.
REQ-023 Push and pop in the same cycle are legal at any occupancy, including full; occupancy is then unchanged.
REQ-024 Address is assigned at stage-1 push: BASE_ADDR + 4*k for the k-th legal word, wrapping modulo 2^32.
REQ-025 count increments on each out handshake and wraps from FFFFh to 0000h.
REQ-026 in_valid with in_ready low: no state change; the request must be held by the source.

Reset
REQ-027 On rst: out_valid=0, in_ready=0 that cycle, out_instr=0, out_addr=BASE_ADDR, err=0, count=0.
REQ-028 On rst: stage 1 and FIFO are emptied and the address counter returns to BASE_ADDR.
REQ-029 Reset mid-operation discards all in-flight words; nothing is emitted for them after reset.
REQ-030 in_ready=1 from the first cycle after rst deasserts.

Structure
REQ-031 A shared package holds the one-hot bit indices, opcode/funct constants, format field offsets, and FIFO_DEPTH/BASE_ADDR defaults.
REQ-032 Sub-module instr_fifo: synchronous FIFO, width 64 (instr+addr), depth FIFO_DEPTH, with count output.
REQ-033 Encoding logic is combinational in stage 1 of instruction_encoder itself.

Verification
REQ-034 add: code bit0, rs=1, rt=2, rd=3 -> out_instr=0x00221820, out_addr=0x00400000, in cycle N+2.
REQ-035 sll: code bit10, rs=7, rt=1, rd=2, shamt=4 -> out_instr=0x00011100 (rs forced 0); lui: code bit22, rt=1, imm=1234h -> out_instr=0x3C011234.
REQ-036 j: code bit29, target=0x0100000 -> 0x08100000; code=0x00000003 -> err=1, no output, next legal word gets the next address.
REQ-037 Backpressure: out_ready=0 with 6 back-to-back requests -> in_ready drops after 4 are accepted; release -> 4 words in order, addresses +4 each.
REQ-038 rst asserted with 3 words buffered -> out_valid=0 next cycle, count=0, next word at BASE_ADDR.
